noc_packet_injector: RTL and testbench

- Network-interface transmitter for one mesh node. It turns a packet command plus a payload stream into a flit sequence: one header flit, then body flits, with the last flit marked as tail.
- Drives a node's local receive port (valid/ready/flit/is_header/is_tail) on the NoC connector. It is the injecting end of the flit interface the router uses to deliver packets.
- A header is launched only when the downstream virtual channel reports ready.

---
 rtl/noc_packet_injector.sv | 143 ++++++++++++++
 tb/tb_noc_packet_injector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - NoC flit injector: packet command + payload stream to header/body/tail flits
//
// Ports:
//   noc_clk, noc_rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready           packet command handshake (cmd_dst_x, cmd_dst_y, cmd_len)
//   pay_valid/pay_ready/pay_data  payload word stream, one word per body flit
//   out_valid/out_ready/out_flit  flit stream toward the router local port
//   out_is_header, out_is_tail    flit position markers
//   out_vc_ready                  downstream VC free; only gates header launch
//   busy                          packet in progress or flit still held
//   pkt_count                     tail flits accepted by the router (wraps)
module noc_packet_injector #(
  parameter int FLIT_WIDTH = 32,
  parameter int X_WIDTH    = 1,
  parameter int Y_WIDTH    = 1,
  parameter int LEN_WIDTH  = 4,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_dst_x,
  input  logic [Y_WIDTH-1:0]    cmd_dst_y,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [FLIT_WIDTH-1:0] pay_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_is_header,
  output logic                  out_is_tail,
  input  logic                  out_vc_ready,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int HDR_BITS = 2*X_WIDTH + 2*Y_WIDTH + LEN_WIDTH + 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  localparam logic [X_WIDTH-1:0] SRC_X_L = X_WIDTH'(SRC_X);
  localparam logic [Y_WIDTH-1:0] SRC_Y_L = Y_WIDTH'(SRC_Y);

  generate
    if (FLIT_WIDTH < HDR_BITS) begin : g_width_check
      $error("noc_packet_injector: FLIT_WIDTH too small for header fields");
    end
  endgenerate

  logic [1:0]            state;
  logic [X_WIDTH-1:0]    dst_x_q;
  logic [Y_WIDTH-1:0]    dst_y_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [7:0]            seq_q;

  logic                  load_en;
  logic                  hdr_fire;
  logic                  body_fire;
  logic [FLIT_WIDTH-1:0] header_flit;

  // Output register may take a new flit when empty or being drained this edge.
  assign load_en   = !out_valid || out_ready;
  assign hdr_fire  = (state == ST_HEAD) && out_vc_ready && load_en;
  // Reset gating keeps both handshakes closed while reset is asserted,
  // including the first reset cycle before state has returned to IDLE.
  assign cmd_ready = (state == ST_IDLE) && !noc_rst;
  assign pay_ready = (state == ST_BODY) && load_en && !noc_rst;
  assign body_fire = pay_valid && pay_ready;
  assign busy      = (state != ST_IDLE) || out_valid;

  // Header fields packed LSB-first, upper bits zero.
  assign header_flit = FLIT_WIDTH'({seq_q, len_q, SRC_Y_L, SRC_X_L, dst_y_q, dst_x_q});

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state         <= ST_IDLE;
      dst_x_q       <= '0;
      dst_y_q       <= '0;
      len_q         <= '0;
      rem_q         <= '0;
      seq_q         <= '0;
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
      pkt_count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            dst_x_q <= cmd_dst_x;
            dst_y_q <= cmd_dst_y;
            len_q   <= cmd_len;
            state   <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (hdr_fire) begin
            rem_q <= len_q;
            seq_q <= seq_q + 8'd1;
            state <= (len_q == '0) ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (body_fire) begin
            rem_q <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A new flit overwrites the register on the same edge the old one
      // drains, so back-to-back flits leave no bubble.
      if (hdr_fire) begin
        out_valid     <= 1'b1;
        out_flit      <= header_flit;
        out_is_header <= 1'b1;
        out_is_tail   <= (len_q == '0);
      end else if (body_fire) begin
        out_valid     <= 1'b1;
        out_flit      <= pay_data;
        out_is_header <= 1'b0;
        out_is_tail   <= (rem_q == LEN_WIDTH'(1));
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && out_is_tail) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - scoreboard bench for noc_packet_injector
module tb_noc_packet_injector;

  logic        noc_clk = 1'b0;
  logic        noc_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_dst_x = '0;
  logic [0:0]  cmd_dst_y = '0;
  logic [3:0]  cmd_len = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [31:0] pay_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_flit;
  logic        out_is_header;
  logic        out_is_tail;
  logic        out_vc_ready = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;

  noc_packet_injector dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y), .cmd_len(cmd_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .out_vc_ready(out_vc_ready), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [31:0] flit;
    bit          hd;
    bit          tl;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int model_pkts = 0;
  int mseq = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0,1
  bit vc_rand = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Header value built from the field layout with plain arithmetic (source node is (0,0)).
  function automatic logic [31:0] hdr(input int dx, input int dy, input int len, input int seq);
    return 32'(dx + dy * 2 + 0 * 4 + 0 * 8 + len * 16 + seq * 256);
  endfunction

  // Downstream ready / VC drivers
  initial begin
    int tog = 0;
    forever begin
      @(posedge noc_clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom % 4) != 0;
        default: begin
          out_ready = (tog == 0) || (tog == 3);
          tog = (tog + 1) % 4;
        end
      endcase
      if (vc_rand) out_vc_ready = ($urandom % 3) != 0;
    end
  end

  // Monitor: stream checks against the scoreboard queue
  initial begin
    bit          held_v = 0;
    logic [31:0] held_flit = '0;
    bit          held_hd = 0;
    bit          held_tl = 0;
    exp_t        e;
    forever begin
      @(negedge noc_clk);
      if (!noc_rst && started) begin
        chk("pkt_count", 64'(pkt_count), 64'(model_pkts & 16'hffff));
        if (held_v) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_flit", 64'({out_flit, out_is_header, out_is_tail}),
              64'({held_flit, held_hd, held_tl}));
        end
        if (out_valid && !out_ready) begin
          chk("pay_ready_stalled", 64'(pay_ready), 64'd0);
          held_v = 1; held_flit = out_flit; held_hd = out_is_header; held_tl = out_is_tail;
        end else begin
          held_v = 0;
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_flit", 64'(out_flit), 64'hdead_0000_0000);
          end else begin
            e = expq.pop_front();
            chk("flit", 64'(out_flit), 64'(e.flit));
            chk("is_header", 64'(out_is_header), 64'(e.hd));
            chk("is_tail", 64'(out_is_tail), 64'(e.tl));
            if (e.tl) model_pkts++;
          end
        end
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic do_reset(input int n);
    noc_rst = 1'b1;
    cmd_valid = 1'b1;
    pay_valid = 1'b0;
    expq.delete();
    model_pkts = 0;
    mseq = 0;
    repeat (n) begin
      @(posedge noc_clk);
      @(negedge noc_clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pay_ready", 64'(pay_ready), 64'd0);
    end
    @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
    cmd_valid = 1'b0;
    started = 1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge noc_clk);
      if (expq.size() == 0 && !busy) done = 1;
    end
    chk("drain_timeout", 64'(done), 64'd1);
    @(posedge noc_clk);
    #1;
  endtask

  task automatic send_pkt(input int dx, input int dy, input int len, input bit fixed,
                          input bit chk_lat, input int vc_hold, input int stop_after);
    logic [31:0] pl[16];
    bit acc;
    exp_t e;
    for (int i = 0; i < len; i++) pl[i] = fixed ? 32'(32'hA1 + i) : $urandom;
    if (vc_hold > 0) out_vc_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_dst_x = 1'(dx);
    cmd_dst_y = 1'(dy);
    cmd_len = 4'(len);
    acc = 0;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge noc_clk);
      acc = cmd_ready;
      @(posedge noc_clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      chk("cmd_timeout", 64'd0, 64'd1);
      return;
    end
    e.flit = hdr(dx, dy, len, mseq); e.hd = 1; e.tl = (len == 0);
    expq.push_back(e);
    mseq = (mseq + 1) % 256;
    for (int i = 0; i < len; i++) begin
      e.flit = pl[i]; e.hd = 0; e.tl = (i == len - 1);
      expq.push_back(e);
    end
    if (chk_lat) begin
      @(negedge noc_clk);
      chk("lat_n1_valid", 64'(out_valid), 64'd0);
      @(negedge noc_clk);
      chk("lat_n2_header", 64'({out_valid, out_is_header}), 64'b11);
      @(posedge noc_clk);
      #1;
    end
    if (vc_hold > 0) begin
      for (int k = 0; k < vc_hold; k++) begin
        @(negedge noc_clk);
        chk("vc_gated_valid", 64'(out_valid), 64'd0);
        @(posedge noc_clk);
        #1;
      end
      out_vc_ready = 1'b1;
      @(negedge noc_clk);
      chk("vc_rise_valid", 64'(out_valid), 64'd0);
      @(negedge noc_clk);
      chk("vc_header", 64'({out_valid, out_is_header}), 64'b11);
      @(posedge noc_clk);
      #1;
    end
    for (int i = 0; i < len && i < stop_after; i++) begin
      pay_data = pl[i];
      acc = 0;
      for (int t = 0; t < 1000 && !acc; t++) begin
        pay_valid = fixed ? 1'b1 : (($urandom % 4) != 0);
        @(negedge noc_clk);
        acc = pay_valid && pay_ready;
        @(posedge noc_clk);
        #1;
      end
      pay_valid = 1'b0;
      if (!acc) begin
        chk("pay_timeout", 64'd0, 64'd1);
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    do_reset(3);

    // Normal packet with fixed payloads and latency check
    ready_mode = 0;
    send_pkt(1, 1, 3, 1, 1, 0, 16);
    wait_idle();
    chk("pkt_count_after_first", 64'(pkt_count), 64'd1);

    // Header-only packet, then a packet showing the incremented sequence
    send_pkt(0, 1, 0, 1, 0, 0, 16);
    wait_idle();
    send_pkt(1, 0, 1, 0, 0, 0, 16);
    wait_idle();

    // Backpressure pattern
    ready_mode = 2;
    send_pkt(1, 0, 2, 0, 0, 0, 16);
    wait_idle();
    ready_mode = 0;

    // VC gating
    send_pkt(0, 0, 2, 0, 0, 5, 16);
    wait_idle();

    // Reset after header and one body flit of a len=4 packet
    send_pkt(1, 1, 4, 1, 0, 0, 1);
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge noc_clk);
      if (expq.size() <= 3) ok = 1;
    end
    chk("midpkt_progress", 64'(ok), 64'd1);
    @(posedge noc_clk);
    #1;
    do_reset(1);
    send_pkt(1, 1, 1, 0, 0, 0, 16);
    wait_idle();

    // Randomised traffic; enough packets to wrap the 8-bit sequence
    ready_mode = 1;
    vc_rand = 1;
    for (int p = 0; p < 300; p++) begin
      send_pkt($urandom % 2, $urandom % 2, (($urandom % 3) == 0) ? 0 : $urandom % 16, 0, 0, 0, 16);
    end
    wait_idle();
    vc_rand = 0;
    out_vc_ready = 1'b1;
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
